reset_seq: RTL and testbench

Reset sequencer that sits directly downstream of the power-on reset generator and consumes its reset output. It waits for PLL lock and then releases peripheral reset and CPU reset in stages. It also re-enters reset on PLL lock loss, on a software reset request or, optionally, on watchdog expiry. It records the cause of the most recent re-reset for firmware.

---
 rtl/reset_seq.sv | 136 +++++++++++++
 tb/tb_reset_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/reset_seq.sv
// Staged reset sequencer: waits for PLL lock, releases peripheral then CPU reset, re-enters reset on events.
// Optional watchdog re-reset is enabled by defining RESET_SEQ_WDT_EN.
module reset_seq #(
  parameter int unsigned PERIPH_DELAY = 16,
  parameter int unsigned CPU_DELAY    = 16,
  parameter int unsigned HOLD_CYCLES  = 8,
  parameter int unsigned WDT_WIDTH    = 20
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pll_locked_i,
  input  logic       soft_rst_i,
  input  logic       wdt_kick_i,
  output logic       rst_periph_o,
  output logic       rst_cpu_o,
  output logic       ready_o,
  output logic [1:0] rst_cause_o
);

  typedef enum logic [2:0] {
    ST_RESET,
    ST_WAIT_LOCK,
    ST_PERIPH_DLY,
    ST_CPU_DLY,
    ST_RUN,
    ST_HOLD
  } state_e;

  localparam logic [7:0] PERIPH_LAST = 8'(PERIPH_DELAY - 1);
  localparam logic [7:0] CPU_LAST    = 8'(CPU_DELAY - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYCLES - 1);

  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;
  localparam logic [1:0] CAUSE_WDT  = 2'b11;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] cause_q, cause_d;
  logic [1:0] sync_q;
  logic       rst_periph_q, rst_cpu_q, ready_q;
  logic       lock_s;
  logic       wdt_expired;

  assign lock_s = sync_q[1];

`ifdef RESET_SEQ_WDT_EN
  logic [WDT_WIDTH-1:0] wdt_q, wdt_d;

  assign wdt_expired = (state_q == ST_RUN) && (wdt_q == '1);

  // Counts only while staying in RUN; any kick or exit from RUN restarts it.
  always_comb begin
    wdt_d = '0;
    if (state_q == ST_RUN && state_d == ST_RUN && !wdt_kick_i)
      wdt_d = wdt_q + {{(WDT_WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) wdt_q <= '0;
    else       wdt_q <= wdt_d;
  end
`else
  logic unused_wdt_kick;
  assign unused_wdt_kick = wdt_kick_i;
  assign wdt_expired     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = cnt_q + 8'd1;
    unique case (state_q)
      ST_RESET:     state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: if (lock_s) state_d = ST_PERIPH_DLY;
      ST_PERIPH_DLY: begin
        if (!lock_s) begin
          state_d = ST_HOLD;
          cause_d = CAUSE_LOCK;
        end else if (cnt_q == PERIPH_LAST) begin
          state_d = ST_CPU_DLY;
        end
      end
      ST_CPU_DLY: begin
        if (!lock_s) begin
          state_d = ST_HOLD;
          cause_d = CAUSE_LOCK;
        end else if (cnt_q == CPU_LAST) begin
          state_d = ST_RUN;
        end
      end
      // Lock loss outranks watchdog expiry, which outranks a software request.
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_HOLD;
          cause_d = CAUSE_LOCK;
        end else if (wdt_expired) begin
          state_d = ST_HOLD;
          cause_d = CAUSE_WDT;
        end else if (soft_rst_i) begin
          state_d = ST_HOLD;
          cause_d = CAUSE_SOFT;
        end
      end
      ST_HOLD:  if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
      default:  state_d = ST_RESET;
    endcase
    if (state_d != state_q) cnt_d = 8'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q       <= 2'b00;
      state_q      <= ST_RESET;
      cnt_q        <= 8'd0;
      cause_q      <= 2'b00;
      rst_periph_q <= 1'b1;
      rst_cpu_q    <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], pll_locked_i};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cause_q      <= cause_d;
      rst_periph_q <= !(state_d == ST_CPU_DLY || state_d == ST_RUN);
      rst_cpu_q    <= (state_d != ST_RUN);
      ready_q      <= (state_d == ST_RUN);
    end
  end

  assign rst_periph_o = rst_periph_q;
  assign rst_cpu_o    = rst_cpu_q;
  assign ready_o      = ready_q;
  assign rst_cause_o  = cause_q;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: power-on timing, lock wait, soft/lock re-reset, mid-sequence reset, watchdog.
// Output vectors are packed as {rst_periph, rst_cpu, ready, cause[1:0]}.
module tb_reset_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pllLocked = 1'b0;
   logic       softRst = 1'b0;
   logic       wdtKick = 1'b0;
   logic       rstPeriph, rstCpu, ready;
   logic [1:0] rstCause;

   int checks = 0;
   int failures = 0;
   int edgeNum = 0;

   reset_seq #(
      .PERIPH_DELAY(16),
      .CPU_DELAY   (16),
      .HOLD_CYCLES (8),
      .WDT_WIDTH   (4)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .pll_locked_i(pllLocked),
      .soft_rst_i  (softRst),
      .wdt_kick_i  (wdtKick),
      .rst_periph_o(rstPeriph),
      .rst_cpu_o   (rstCpu),
      .ready_o     (ready),
      .rst_cause_o (rstCause)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   // Drives all inputs at once; called one time unit after an edge
   task automatic applyStimulus(input logic r, input logic lk, input logic sr, input logic wk);
      rst = r;
      pllLocked = lk;
      softRst = sr;
      wdtKick = wk;
   endtask

   // Advances until edge number e has just occurred, sampling one unit after it
   task automatic stepTo(input int e);
      while (edgeNum < e) begin
         @(posedge clk);
         #1;
         edgeNum++;
      end
   endtask

   // Single comparison point: counts, and reports any mismatch
   task automatic checkOutput(input string tag, input logic [4:0] observed, input logic [4:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed %b, expected %b", tag, observed, expected);
      end
   endtask

   // Steps to edge e and compares the packed outputs there
   task automatic checkAt(input int e, input logic [4:0] expected, input string tag);
      stepTo(e);
      checkOutput($sformatf("%s@E%0d", tag, e), {rstPeriph, rstCpu, ready, rstCause}, expected);
   endtask

   // Restarts edge numbering so the first edge with rst low is E0
   task automatic releaseReset(input logic lk);
      applyStimulus(1'b0, lk, 1'b0, 1'b0);
      edgeNum = -1;
   endtask

   // Safety net against a hung run
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      $display("[TB] reset_seq directed test start");

      // Power-on with lock already present
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("por_reset", {rstPeriph, rstCpu, ready, rstCause}, 5'b11000);
      releaseReset(1'b1);
      checkAt(0,  5'b11000, "por_wait");
      checkAt(17, 5'b11000, "por_periph_held");
      checkAt(18, 5'b01000, "por_periph_rel");
      checkAt(33, 5'b01000, "por_cpu_held");
      checkAt(34, 5'b00100, "por_run");

      // Software reset from RUN, then full re-sequence
      stepTo(36);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      checkAt(37, 5'b11010, "soft_hold");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkAt(44, 5'b11010, "soft_hold_end");
      checkAt(61, 5'b11010, "soft_periph_held");
      checkAt(62, 5'b01010, "soft_periph_rel");
      checkAt(77, 5'b01010, "soft_cpu_held");
      checkAt(78, 5'b00110, "soft_run");

      // Another soft re-reset, then rst_i pulsed during PERIPH_DLY
      stepTo(80);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      checkAt(81, 5'b11010, "soft2_hold");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      stepTo(92);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkAt(93, 5'b11000, "midseq_reset");
      releaseReset(1'b1);
      checkAt(0,  5'b11000, "rpor_wait");
      checkAt(17, 5'b11000, "rpor_periph_held");
      checkAt(18, 5'b01000, "rpor_periph_rel");
      checkAt(34, 5'b00100, "rpor_run");

      // Lock loss in CPU_DLY with a soft request in the same window
      stepTo(40);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      checkAt(41, 5'b11010, "soft3_hold");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkAt(66, 5'b01010, "cpudly_entry");
      stepTo(70);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkAt(71, 5'b01010, "drop_soft_ignored");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkAt(72, 5'b01010, "drop_sync_delay");
      checkAt(73, 5'b11001, "drop_hold");
      stepTo(75);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkAt(76, 5'b11001, "hold_soft_ignored");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkAt(90, 5'b11001, "wait_relock");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkAt(108, 5'b11001, "relock_periph_held");
      checkAt(109, 5'b01001, "relock_periph_rel");
      checkAt(124, 5'b01001, "relock_cpu_held");
      checkAt(125, 5'b00101, "relock_run");

      // Watchdog: no kicks from RUN entry at E125
`ifdef RESET_SEQ_WDT_EN
      checkAt(140, 5'b00101, "wdt_before_expiry");
      checkAt(141, 5'b11011, "wdt_expiry_hold");
      checkAt(166, 5'b01011, "wdt_periph_rel");
      checkAt(182, 5'b00111, "wdt_run");
      for (int i = 0; i < 20; i++) begin
         checkAt(edgeNum + 9, 5'b00111, "wdt_kicked_run");
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
         stepTo(edgeNum + 1);
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      end
      checkOutput("wdt_kicked_end", {rstPeriph, rstCpu, ready, rstCause}, 5'b00111);
`else
      checkAt(141, 5'b00101, "nowdt_still_run");
      for (int i = 0; i < 20; i++) begin
         checkAt(edgeNum + 9, 5'b00101, "nowdt_run");
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
         stepTo(edgeNum + 1);
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      end
      checkOutput("nowdt_end", {rstPeriph, rstCpu, ready, rstCause}, 5'b00101);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
